// File: rtl/bram_sp_arbiter_if.sv
// Request/response channel between one client engine and the shared BRAM arbiter.
// The client drives the request fields; the arbiter drives ready and the response.
interface bram_sp_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              valid;
    logic              ready;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] di;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output valid, we, lock, addr, di,
        input  ready, rsp_valid, rsp_data
    );

    modport slave (
        input  valid, we, lock, addr, di,
        output ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/bram_sp_arbiter.sv
// Two-requester round-robin arbiter with capped locked bursts in front of an
// inferred single-port write-first BRAM; one response per accepted beat, one cycle later.
module bram_sp_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic               clk,
    input  logic               rst,
    bram_sp_arbiter_if.slave   a,
    bram_sp_arbiter_if.slave   b
);
    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
    localparam bit              LOCK_EN = (MAX_BURST > 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t            state_q, state_d, eff_state_s;
    logic              rr_q, rr_d, eff_rr_s;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d, cnt_inc_s;
    logic              grant_a_s, grant_b_s;

    logic              ram_en_s, ram_we_s;
    logic [ADDR_W-1:0] ram_addr_s;
    logic [DATA_W-1:0] ram_di_s;
    logic [DATA_W-1:0] ram_dout_q;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
    logic [DATA_W-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;

    assign cnt_inc_s = burst_cnt_q + CNT_W'(1);

    // FSM state register: ownership state, round-robin pointer and burst length
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // FSM output logic: an owner dropping valid is treated as IDLE with priority to the other port
    always_comb begin
        eff_state_s = IDLE;
        eff_rr_s    = rr_q;
        grant_a_s   = 1'b0;
        grant_b_s   = 1'b0;
        case (state_q)
            OWN_A: begin
                if (a.valid) begin
                    eff_state_s = OWN_A;
                    eff_rr_s    = rr_q;
                end else begin
                    eff_state_s = IDLE;
                    eff_rr_s    = 1'b1;
                end
            end
            OWN_B: begin
                if (b.valid) begin
                    eff_state_s = OWN_B;
                    eff_rr_s    = rr_q;
                end else begin
                    eff_state_s = IDLE;
                    eff_rr_s    = 1'b0;
                end
            end
            default: begin
                eff_state_s = IDLE;
                eff_rr_s    = rr_q;
            end
        endcase
        if (rst) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else begin
            case (eff_state_s)
                OWN_A:   grant_a_s = a.valid;
                OWN_B:   grant_b_s = b.valid;
                default: begin
                    grant_a_s = a.valid & (~b.valid | ~eff_rr_s);
                    grant_b_s = b.valid & (~a.valid |  eff_rr_s);
                end
            endcase
        end
    end

    // FSM next-state logic: lock entry, burst counting and release back to IDLE
    always_comb begin
        state_d     = eff_state_s;
        rr_d        = eff_rr_s;
        burst_cnt_d = burst_cnt_q;
        case (eff_state_s)
            OWN_A: begin
                if (grant_a_s && (!a.lock || cnt_inc_s == MAX_CNT)) begin
                    state_d     = IDLE;
                    rr_d        = 1'b1;
                    burst_cnt_d = '0;
                end else if (grant_a_s) begin
                    burst_cnt_d = cnt_inc_s;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            OWN_B: begin
                if (grant_b_s && (!b.lock || cnt_inc_s == MAX_CNT)) begin
                    state_d     = IDLE;
                    rr_d        = 1'b0;
                    burst_cnt_d = '0;
                end else if (grant_b_s) begin
                    burst_cnt_d = cnt_inc_s;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
                if (grant_a_s && a.lock && LOCK_EN) begin
                    state_d     = OWN_A;
                    burst_cnt_d = CNT_W'(1);
                end else if (grant_a_s) begin
                    rr_d = 1'b1;
                end else if (grant_b_s && b.lock && LOCK_EN) begin
                    state_d     = OWN_B;
                    burst_cnt_d = CNT_W'(1);
                end else if (grant_b_s) begin
                    rr_d = 1'b0;
                end else begin
                    rr_d = eff_rr_s;
                end
            end
        endcase
    end

    // RAM port mux: the granted requester owns the single port for this cycle
    always_comb begin
        ram_en_s   = grant_a_s | grant_b_s;
        ram_we_s   = 1'b0;
        ram_addr_s = a.addr;
        ram_di_s   = a.di;
        if (grant_b_s) begin
            ram_we_s   = b.we;
            ram_addr_s = b.addr;
            ram_di_s   = b.di;
        end else begin
            ram_we_s   = grant_a_s & a.we;
            ram_addr_s = a.addr;
            ram_di_s   = a.di;
        end
    end

    // Write-first single-port RAM with its output register; contents are never reset
    always_ff @(posedge clk) begin
        if (ram_en_s) begin
            if (ram_we_s) begin
                mem[ram_addr_s] <= ram_di_s;
                ram_dout_q      <= ram_di_s;
            end else begin
                ram_dout_q      <= mem[ram_addr_s];
            end
        end
    end

    // Response routing: remember who owns the RAM output, keep the last data per port
    always_comb begin
        pend_a_d = grant_a_s;
        pend_b_d = grant_b_s;
        hold_a_d = pend_a_q ? ram_dout_q : hold_a_q;
        hold_b_d = pend_b_q ? ram_dout_q : hold_b_q;
    end

    // Response flags and held data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_a_q <= 1'b0;
            pend_b_q <= 1'b0;
            hold_a_q <= '0;
            hold_b_q <= '0;
        end else begin
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
        end
    end

    assign a.ready     = grant_a_s;
    assign b.ready     = grant_b_s;
    assign a.rsp_valid = pend_a_q;
    assign b.rsp_valid = pend_b_q;
    assign a.rsp_data  = pend_a_q ? ram_dout_q : hold_a_q;
    assign b.rsp_data  = pend_b_q ? ram_dout_q : hold_b_q;
endmodule
